nlc_mch_horner: RTL and testbench
=================================

NLC_MCH_HORNER -- requirements
Module: nlc_mch_horner

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XW, 21: ADC sample width, signed.
- CW, 40: coefficient and accumulator width, signed fixed point.
- FRAC, 16: fraction bits of CW values.
- ORDER, 10: polynomial order.
- NCH, 4: channel count.
- FIFO_DEPTH, 4: input FIFO entries (power of 2).
- CHW = clog2(NCH) and IW = clog2(ORDER+3) SHALL be derived, not settable.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- srdyi, in, 1: input sample valid.
- x_adc, in, XW: ADC sample, two's complement.
- ch_i, in, CHW: channel of x_adc.
- drdy, out, 1: input ready; equals FIFO not full.
- srdyo, out, 1: output valid, one-cycle pulse.
- x_lin, out, XW: corrected sample.
- ch_o, out, CHW: channel of x_lin.
- section_o, out, 2: section used for x_lin.
- section_limit, in, XW-1: magnitude that separates the sections.
- cfg_we, in, 1: configuration write strobe.
- cfg_addr, in, CHW+2+IW: concatenation {ch, sec, idx}.
- cfg_data, in, CW: configuration word.
- cfg_rdy, out, 1: configuration writes are accepted.
- ovf, out, 1: sticky flag; a sample was dropped.

Function
REQ-003 A sample SHALL be pushed into the FIFO when srdyi=1 and drdy=1.
REQ-004 When srdyi=1 and drdy=0, the sample SHALL be dropped and ovf set. A pop in the same cycle SHALL NOT make room for that sample.
REQ-005 Section SHALL be chosen from x as follows, where |x| = -2^(XW-1) maps to 2^(XW-1):
- x>0 and |x|>limit: sec 3.
- x>0 and |x|<=limit: sec 2.
- x<=0 and |x|<=limit: sec 1.
- x<=0 and |x|>limit: sec 0.
REQ-006 The configuration store SHALL hold NCH×4×(ORDER+3) CW-bit words. Within each {ch, sec} block:
- idx 0..ORDER: coefficient c[idx].
- idx ORDER+1: neg_mean.
- idx ORDER+2: recip_stdev.
- Writes with idx > ORDER+2 SHALL be ignored.
REQ-007 cfg_rdy SHALL be 1 only in IDLE with the FIFO empty. A cfg_we seen while cfg_rdy=0 SHALL be dropped. An accepted write SHALL be visible from the next cycle.
REQ-008 The FSM SHALL step through IDLE, NORM, HORNER and DONE:
- IDLE: if the FIFO is not empty, pop; latch x, ch and sec; go to NORM.
- NORM: u = sat(((x<<FRAC)+neg_mean)*recip_stdev >>> FRAC); acc = c[ORDER]; k=1; go to HORNER.
- HORNER: acc = sat((acc*u >>> FRAC) + c[ORDER-k]); k++; after k=ORDER go to DONE.
- DONE: x_lin = satXW((acc + 2^(FRAC-1)) >>> FRAC); drive ch_o and section_o; srdyo=1 for this cycle only; go to IDLE.
REQ-009 Products SHALL be full 2×CW bits. ">>>" SHALL be an arithmetic (floor) shift. sat SHALL clamp to CW-bit signed and satXW to XW-bit signed.
REQ-010 Latency SHALL be fixed: with the block idle and the FIFO empty, srdyo is high in the cycle after the (ORDER+3)th rising edge following the capturing edge. Throughput SHALL be one sample per ORDER+3 cycles.
REQ-011 x_lin, ch_o and section_o SHALL hold their values between srdyo pulses.
REQ-012 Samples SHALL be output in acceptance order, regardless of channel.

Reset
REQ-013 When reset=0, the block SHALL asynchronously clear:
- FSM to IDLE, FIFO empty, configuration store to 0.
- srdyo=0, x_lin=0, ch_o=0, section_o=0, ovf=0.
- drdy=1 and cfg_rdy=1 once reset is released.
REQ-014 Reset asserted mid-computation SHALL abort the computation with no srdyo and discard all FIFO contents.

Structure
REQ-015 Package nlc_pkg SHALL hold the state enum, the section enum (SEC0..SEC3), the idx offsets (NEG_MEAN_IDX, RSTD_IDX) and the sat function.
REQ-016 The input buffer SHALL be a sub-module nlc_fifo (a synchronous FIFO carrying {ch, x}) with push, pop, full and empty.
REQ-017 The datapath SHALL contain exactly one CW×CW multiplier and one adder, shared by NORM and HORNER.

Verification
REQ-018 The bench SHALL use the default parameters and cover these scenarios:
- Identity: ch0, all secs, c1=1.0, other c=0, neg_mean=0, rstd=1.0; x=1000 → x_lin=1000, section_o=2 (limit 5000); srdyo high exactly 13 cycles after capture.
- Normalisation: neg_mean=-1000.0, rstd=0.5, identity poly; x=3000 → x_lin=1000.
- Saturation: c2=1.0, rstd=1.0; x=1000 → 1000000; x=2000 → 1048575; x=-2000 with sec0 configured the same way → 1048575.
- Section boundaries: limit=500; x=500 → sec 2, x=501 → sec 3, x=0 → sec 1, x=-501 → sec 0, x=-1048576 → sec 0.
- FIFO/ovf: hold srdyi=1 for 8 cycles on ch 0..3 → 5 accepted (1 popped plus 4 buffered), drdy=0 afterwards, ovf=1, outputs in order with correct ch_o.
- Config and reset: cfg_we while busy is dropped (output unchanged); reset pulsed during HORNER → no srdyo, all outputs 0, store cleared.

Source files
------------

// File: rtl/nlc_pkg.sv
// Shared types and helpers for the multi-channel Horner linearisation corrector.
package nlc_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_NORM, ST_HORNER, ST_DONE} state_e;
  typedef enum logic [1:0] {SEC0, SEC1, SEC2, SEC3} sec_e;

  // Offsets above the top coefficient index ORDER within one {ch, sec} block
  localparam int NEG_MEAN_IDX = 1;
  localparam int RSTD_IDX     = 2;

  localparam int SAT_W = 128;

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                   input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nlc_fifo.sv
// Synchronous FIFO for {ch, x}; the caller guarantees no push when full, no pop when empty.
module nlc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/nlc_mch_horner.sv
// Per-channel, per-section polynomial linearisation of ADC samples using Horner's rule
// on a single shared multiplier and adder, one sample every ORDER+3 cycles.
module nlc_mch_horner
  import nlc_pkg::*;
#(
  parameter  int XW         = 21,
  parameter  int CW         = 40,
  parameter  int FRAC       = 16,
  parameter  int ORDER      = 10,
  parameter  int NCH        = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int CHW        = $clog2(NCH),
  localparam int IW         = $clog2(ORDER + 3)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 srdyi,
  input  logic signed [XW-1:0] x_adc,
  input  logic [CHW-1:0]       ch_i,
  output logic                 drdy,
  output logic                 srdyo,
  output logic signed [XW-1:0] x_lin,
  output logic [CHW-1:0]       ch_o,
  output logic [1:0]           section_o,
  input  logic [XW-2:0]        section_limit,
  input  logic                 cfg_we,
  input  logic [CHW+2+IW-1:0]  cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 cfg_rdy,
  output logic                 ovf
);

  localparam int NW = ORDER + 3;
  localparam int PW = 2 * CW;
  localparam int AW = 2 * CW - FRAC + 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(ORDER);
  localparam logic [IW-1:0] IDX_NM  = IW'(ORDER + NEG_MEAN_IDX);
  localparam logic [IW-1:0] IDX_RS  = IW'(ORDER + RSTD_IDX);
  localparam logic signed [AW-1:0] HALF = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  function automatic sec_e sec_of(input logic signed [XW-1:0] x, input logic [XW-2:0] lim);
    logic [XW-1:0] mag;
    logic          big;
    // Negating the most negative code wraps to 2^(XW-1), which is correct as unsigned
    mag = x[XW-1] ? XW'(-x) : XW'(x);
    big = (mag > {1'b0, lim});
    if (!x[XW-1] && (x != '0)) return big ? SEC3 : SEC2;
    return big ? SEC0 : SEC1;
  endfunction

  state_e                state_q;
  logic [IW-1:0]         k_q;
  logic [CHW-1:0]        ch_q;
  sec_e                  sec_q;
  logic                  srdyo_q;
  logic signed [XW-1:0]  x_lin_q;
  logic signed [XW-1:0]  x_lin_d;
  logic [CHW-1:0]        ch_o_q;
  sec_e                  sec_o_q;
  logic                  ovf_q;
  logic signed [CW-1:0]  acc_q, acc_d;
  logic signed [CW-1:0]  u_q, u_d;
  logic signed [CW-1:0]  cfg_q [NCH][4][NW];

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CHW+XW-1:0]     fifo_dout;
  logic [CHW-1:0]        head_ch;
  logic signed [XW-1:0]  head_x;
  sec_e                  head_sec;

  logic [CHW-1:0]        wch;
  logic [1:0]            wsec;
  logic [IW-1:0]         widx;

  logic signed [CW-1:0]  mul_b;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  add_a, add_b, sum;

  assign fifo_push = srdyi && !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  nlc_fifo #(.W(CHW + XW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({ch_i, x_adc}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_ch  = fifo_dout[CHW+XW-1:XW];
  assign head_x   = fifo_dout[XW-1:0];
  assign head_sec = sec_of(head_x, section_limit);

  assign {wch, wsec, widx} = cfg_addr;
  assign cfg_rdy = (state_q == ST_IDLE) && fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++)
        for (int s = 0; s < 4; s++)
          for (int i = 0; i < NW; i++)
            cfg_q[c][s][i] <= '0;
    end else if (cfg_we && cfg_rdy && (widx <= IDX_RS) && (int'(wch) < NCH)) begin
      cfg_q[wch][wsec][widx] <= cfg_data;
    end
  end

  // Shared datapath: the pop cycle pre-adds neg_mean so NORM needs only the multiplier
  always_comb begin
    mul_b = (state_q == ST_NORM) ? cfg_q[ch_q][sec_q][IDX_RS] : u_q;
    prod  = PW'(acc_q) * PW'(mul_b);
    add_a = AW'(acc_q);
    add_b = HALF;
    case (state_q)
      ST_IDLE: begin
        add_a = AW'(head_x) <<< FRAC;
        add_b = AW'(cfg_q[head_ch][head_sec][IDX_NM]);
      end
      ST_HORNER: begin
        add_a = AW'(prod >>> FRAC);
        add_b = AW'(cfg_q[ch_q][sec_q][IDX_TOP - k_q]);
      end
      default: ;
    endcase
    sum = add_a + add_b;

    acc_d   = acc_q;
    u_d     = u_q;
    x_lin_d = XW'(sat(SAT_W'(sum >>> FRAC), XW));
    case (state_q)
      ST_IDLE:   if (!fifo_empty) acc_d = CW'(sat(SAT_W'(sum), CW));
      ST_NORM: begin
        u_d   = CW'(sat(SAT_W'(prod >>> FRAC), CW));
        acc_d = cfg_q[ch_q][sec_q][IDX_TOP];
      end
      ST_HORNER: acc_d = CW'(sat(SAT_W'(sum), CW));
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    u_q   <= u_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      ch_q    <= '0;
      sec_q   <= SEC0;
      srdyo_q <= 1'b0;
      x_lin_q <= '0;
      ch_o_q  <= '0;
      sec_o_q <= SEC0;
      ovf_q   <= 1'b0;
    end else begin
      srdyo_q <= 1'b0;
      if (srdyi && fifo_full) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            ch_q    <= head_ch;
            sec_q   <= head_sec;
            state_q <= ST_NORM;
          end
        end
        ST_NORM: begin
          k_q     <= IW'(1);
          state_q <= ST_HORNER;
        end
        ST_HORNER: begin
          k_q <= k_q + IW'(1);
          if (k_q == IDX_TOP) state_q <= ST_DONE;
        end
        ST_DONE: begin
          x_lin_q <= x_lin_d;
          ch_o_q  <= ch_q;
          sec_o_q <= sec_q;
          srdyo_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign drdy      = !fifo_full;
  assign srdyo     = srdyo_q;
  assign x_lin     = x_lin_q;
  assign ch_o      = ch_o_q;
  assign section_o = sec_o_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nlc_mch_horner.sv
// Directed bench for nlc_mch_horner with default parameters (Q.16 coefficients).
module tb_nlc_mch_horner;

  localparam logic signed [39:0] ONE = 40'sd65536;

  logic               clk;
  logic               reset;
  logic               srdyi;
  logic signed [20:0] x_adc;
  logic [1:0]         ch_i;
  logic               drdy;
  logic               srdyo;
  logic signed [20:0] x_lin;
  logic [1:0]         ch_o;
  logic [1:0]         section_o;
  logic [19:0]        section_limit;
  logic               cfg_we;
  logic [7:0]         cfg_addr;
  logic signed [39:0] cfg_data;
  logic               cfg_rdy;
  logic               ovf;

  int total = 0;
  int bad   = 0;

  nlc_mch_horner dut (
    .clk           (clk),
    .reset         (reset),
    .srdyi         (srdyi),
    .x_adc         (x_adc),
    .ch_i          (ch_i),
    .drdy          (drdy),
    .srdyo         (srdyo),
    .x_lin         (x_lin),
    .ch_o          (ch_o),
    .section_o     (section_o),
    .section_limit (section_limit),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_rdy       (cfg_rdy),
    .ovf           (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cfg_wr(input int ch, input int sec, input int idx, input logic signed [39:0] d);
    cfg_we   = 1'b1;
    cfg_addr = {ch[1:0], sec[1:0], idx[3:0]};
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_poly(input int ch, input int sec, input logic signed [39:0] c1,
                          input logic signed [39:0] c2, input logic signed [39:0] nm,
                          input logic signed [39:0] rs);
    logic signed [39:0] d;
    for (int idx = 0; idx < 13; idx++) begin
      d = '0;
      if (idx == 1)  d = c1;
      if (idx == 2)  d = c2;
      if (idx == 11) d = nm;
      if (idx == 12) d = rs;
      cfg_wr(ch, sec, idx, d);
    end
  endtask

  task automatic cfg_all(input int ch, input logic signed [39:0] c1, input logic signed [39:0] c2,
                         input logic signed [39:0] nm, input logic signed [39:0] rs);
    for (int s = 0; s < 4; s++) cfg_poly(ch, s, c1, c2, nm, rs);
  endtask

  // Push one sample and wait for its result; lat = edges after capture, -1 on timeout
  task automatic run_one(input logic signed [20:0] x, input int ch, output int lat);
    srdyi = 1'b1;
    x_adc = x;
    ch_i  = ch[1:0];
    @(negedge clk);
    srdyi = 1'b0;
    lat   = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (srdyo === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (srdyo !== 1'b0) begin bad++; $display("FAIL reset_srdyo got=%0b exp=0", srdyo); end
    total++; if (x_lin !== 21'sd0) begin bad++; $display("FAIL reset_x_lin got=%0d exp=0", x_lin); end
    total++; if (ch_o !== 2'd0) begin bad++; $display("FAIL reset_ch_o got=%0d exp=0", ch_o); end
    total++; if (section_o !== 2'd0) begin bad++; $display("FAIL reset_section got=%0d exp=0", section_o); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (drdy !== 1'b1) begin bad++; $display("FAIL reset_drdy got=%0b exp=1", drdy); end
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL reset_cfg_rdy got=%0b exp=1", cfg_rdy); end
  endtask

  task automatic test_identity;
    int lat;
    section_limit = 20'd5000;
    cfg_all(0, ONE, 40'sd0, 40'sd0, ONE);
    run_one(21'sd1000, 0, lat);
    total++; if (lat != 13) begin bad++; $display("FAIL ident_latency got=%0d exp=13", lat); end
    total++; if (x_lin !== 21'sd1000) begin bad++; $display("FAIL ident_x_lin got=%0d exp=1000", x_lin); end
    total++; if (section_o !== 2'd2) begin bad++; $display("FAIL ident_section got=%0d exp=2", section_o); end
    total++; if (ch_o !== 2'd0) begin bad++; $display("FAIL ident_ch_o got=%0d exp=0", ch_o); end
    @(negedge clk);
    total++; if (srdyo !== 1'b0) begin bad++; $display("FAIL ident_pulse got=%0b exp=0", srdyo); end
    repeat (3) @(negedge clk);
    total++; if (x_lin !== 21'sd1000) begin bad++; $display("FAIL ident_hold got=%0d exp=1000", x_lin); end
    run_one(-21'sd3000, 0, lat);
    total++; if (x_lin !== -21'sd3000) begin bad++; $display("FAIL ident_neg got=%0d exp=-3000", x_lin); end
    total++; if (section_o !== 2'd1) begin bad++; $display("FAIL ident_neg_sec got=%0d exp=1", section_o); end
  endtask

  task automatic test_norm;
    int lat;
    cfg_all(0, ONE, 40'sd0, -40'sd65536000, 40'sd32768);
    run_one(21'sd3000, 0, lat);
    total++; if (lat != 13) begin bad++; $display("FAIL norm_latency got=%0d exp=13", lat); end
    total++; if (x_lin !== 21'sd1000) begin bad++; $display("FAIL norm_pos got=%0d exp=1000", x_lin); end
    run_one(-21'sd1000, 0, lat);
    total++; if (x_lin !== -21'sd1000) begin bad++; $display("FAIL norm_neg got=%0d exp=-1000", x_lin); end
  endtask

  task automatic test_saturation;
    int lat;
    section_limit = 20'd1500;
    cfg_all(0, 40'sd0, ONE, 40'sd0, ONE);
    run_one(21'sd1000, 0, lat);
    total++; if (x_lin !== 21'sd1000000) begin bad++; $display("FAIL sat_square got=%0d exp=1000000", x_lin); end
    run_one(21'sd2000, 0, lat);
    total++; if (x_lin !== 21'sd1048575) begin bad++; $display("FAIL sat_pos got=%0d exp=1048575", x_lin); end
    total++; if (section_o !== 2'd3) begin bad++; $display("FAIL sat_pos_sec got=%0d exp=3", section_o); end
    run_one(-21'sd2000, 0, lat);
    total++; if (x_lin !== 21'sd1048575) begin bad++; $display("FAIL sat_sec0 got=%0d exp=1048575", x_lin); end
    total++; if (section_o !== 2'd0) begin bad++; $display("FAIL sat_sec0_sec got=%0d exp=0", section_o); end
    cfg_poly(0, 3, 40'sd0, -ONE, 40'sd0, ONE);
    run_one(21'sd2000, 0, lat);
    total++; if (x_lin !== -21'sd1048576) begin bad++; $display("FAIL sat_neg got=%0d exp=-1048576", x_lin); end
  endtask

  task automatic test_sections;
    logic signed [20:0] xs [5];
    logic [1:0]         secs [5];
    int lat;
    xs[0] = 21'sd500;   secs[0] = 2'd2;
    xs[1] = 21'sd501;   secs[1] = 2'd3;
    xs[2] = 21'sd0;     secs[2] = 2'd1;
    xs[3] = -21'sd501;  secs[3] = 2'd0;
    xs[4] = -21'sd1048576; secs[4] = 2'd0;
    section_limit = 20'd500;
    cfg_all(0, ONE, 40'sd0, 40'sd0, ONE);
    for (int i = 0; i < 5; i++) begin
      run_one(xs[i], 0, lat);
      total++; if (section_o !== secs[i]) begin bad++; $display("FAIL section_%0d got=%0d exp=%0d", i, section_o, secs[i]); end
      total++; if (x_lin !== xs[i]) begin bad++; $display("FAIL section_x_%0d got=%0d exp=%0d", i, x_lin, xs[i]); end
    end
  endtask

  task automatic test_fifo_ovf;
    logic signed [20:0] got_x [5];
    logic [1:0]         got_ch [5];
    int                 got_t [5];
    int                 got;
    int                 extra;
    section_limit = 20'd5000;
    for (int c = 0; c < 4; c++) cfg_all(c, ONE, 40'sd0, 40'sd0, ONE);
    for (int i = 0; i < 8; i++) begin
      srdyi = 1'b1;
      x_adc = 21'(100 + i);
      ch_i  = 2'(i % 4);
      @(negedge clk);
    end
    srdyi = 1'b0;
    total++; if (drdy !== 1'b0) begin bad++; $display("FAIL fifo_drdy_full got=%0b exp=0", drdy); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL fifo_ovf got=%0b exp=1", ovf); end
    total++; if (cfg_rdy !== 1'b0) begin bad++; $display("FAIL fifo_cfg_rdy_busy got=%0b exp=0", cfg_rdy); end
    got = 0;
    for (int cyc = 1; cyc <= 120 && got < 5; cyc++) begin
      @(negedge clk);
      if (srdyo === 1'b1) begin
        got_x[got] = x_lin; got_ch[got] = ch_o; got_t[got] = cyc;
        got++;
      end
    end
    total++; if (got != 5) begin bad++; $display("FAIL fifo_count got=%0d exp=5", got); end
    for (int j = 0; j < got; j++) begin
      total++; if (got_x[j] !== 21'(100 + j)) begin bad++; $display("FAIL fifo_x_%0d got=%0d exp=%0d", j, got_x[j], 100 + j); end
      total++; if (got_ch[j] !== 2'(j % 4)) begin bad++; $display("FAIL fifo_ch_%0d got=%0d exp=%0d", j, got_ch[j], j % 4); end
    end
    if (got >= 2) begin
      total++; if (got_t[1] - got_t[0] != 13) begin bad++; $display("FAIL fifo_throughput got=%0d exp=13", got_t[1] - got_t[0]); end
    end
    extra = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (srdyo === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL fifo_dropped_emitted got=%0d exp=0", extra); end
    total++; if (drdy !== 1'b1) begin bad++; $display("FAIL fifo_drdy_drained got=%0b exp=1", drdy); end
  endtask

  task automatic test_cfg_busy;
    int lat;
    int seen;
    srdyi = 1'b1; x_adc = 21'sd1234; ch_i = 2'd0;
    @(negedge clk);
    srdyi = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cfg_rdy !== 1'b0) begin bad++; $display("FAIL busy_cfg_rdy got=%0b exp=0", cfg_rdy); end
    cfg_wr(0, 2, 1, 40'sd0);
    seen = 0;
    for (int n = 0; n < 30 && seen == 0; n++) begin
      @(negedge clk);
      if (srdyo === 1'b1) seen = 1;
    end
    total++; if (seen != 1) begin bad++; $display("FAIL busy_timeout got=%0d exp=1", seen); end
    total++; if (x_lin !== 21'sd1234) begin bad++; $display("FAIL busy_x_lin got=%0d exp=1234", x_lin); end
    run_one(21'sd777, 0, lat);
    total++; if (x_lin !== 21'sd777) begin bad++; $display("FAIL busy_store_kept got=%0d exp=777", x_lin); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int pulses;
    srdyi = 1'b1; x_adc = 21'sd2000; ch_i = 2'd0;
    @(negedge clk);
    x_adc = 21'sd2001;
    @(negedge clk);
    srdyi = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (srdyo !== 1'b0) begin bad++; $display("FAIL mid_srdyo got=%0b exp=0", srdyo); end
    total++; if (x_lin !== 21'sd0) begin bad++; $display("FAIL mid_x_lin got=%0d exp=0", x_lin); end
    total++; if (ch_o !== 2'd0) begin bad++; $display("FAIL mid_ch_o got=%0d exp=0", ch_o); end
    total++; if (section_o !== 2'd0) begin bad++; $display("FAIL mid_section got=%0d exp=0", section_o); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%0b exp=0", ovf); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (drdy !== 1'b1) begin bad++; $display("FAIL mid_drdy got=%0b exp=1", drdy); end
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL mid_cfg_rdy got=%0b exp=1", cfg_rdy); end
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (srdyo === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_output got=%0d exp=0", pulses); end
    section_limit = 20'd5000;
    run_one(21'sd1000, 0, lat);
    total++; if (lat != 13) begin bad++; $display("FAIL mid_after_latency got=%0d exp=13", lat); end
    total++; if (x_lin !== 21'sd0) begin bad++; $display("FAIL mid_store_cleared got=%0d exp=0", x_lin); end
    total++; if (section_o !== 2'd2) begin bad++; $display("FAIL mid_after_section got=%0d exp=2", section_o); end
  endtask

  initial begin
    reset         = 1'b0;
    srdyi         = 1'b0;
    x_adc         = '0;
    ch_i          = '0;
    section_limit = 20'd5000;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_data      = '0;
    test_reset;
    test_identity;
    test_norm;
    test_saturation;
    test_sections;
    test_fifo_ovf;
    test_cfg_busy;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
